alu_share_arbiter: RTL

Sequencer and arbiter that shares the single 32-bit ALU between two requesters, port 0 (execute-stage ALU ops) and port 1 (branch/compare unit). It accepts one operation at a time with a valid/ready handshake and uses round-robin priority. It drives the shared ALU's control code and operands for exactly one cycle, then holds the registered result on the winner's response port until the requester accepts it.

---
 rtl/alu_share_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// alu_share_arbiter
//
// Shares one 32-bit combinational ALU between two requesters:
//   port 0 - execute-stage ALU operations
//   port 1 - branch/compare unit
// One operation is in flight at a time. Requests use a valid/ready handshake,
// and a 1-bit round-robin pointer arbitrates between the ports. The ALU is
// driven for exactly one cycle (EXEC). Its result is then registered and held
// on the winner's response port (RESP) until that requester accepts it.
// Illegal control codes (8-15) skip EXEC and answer with an error response.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   req_valid_i    [1:0]  per-port request valid
//   req_ready_o    [1:0]  per-port request accepted this cycle
//   req_ctrl0_i    [3:0]  ALU control code, port 0
//   req_ctrl1_i    [3:0]  ALU control code, port 1
//   req_src1_0_i   [31:0] operand 1, port 0
//   req_src2_0_i   [31:0] operand 2, port 0
//   req_src1_1_i   [31:0] operand 1, port 1
//   req_src2_1_i   [31:0] operand 2, port 1
//   resp_valid_o   [1:0]  response valid, one-hot to the granted port
//   resp_ready_i   [1:0]  per-port response accept
//   resp_result_o  [31:0] registered ALU result
//   resp_zero_o           registered ALU zero flag
//   resp_err_o            illegal control code flag
//   alu_ctrl_o     [3:0]  control code to the shared ALU
//   alu_src1_o     [31:0] operand 1 to the shared ALU
//   alu_src2_o     [31:0] operand 2 to the shared ALU
//   alu_result_i   [31:0] combinational ALU result
//   alu_zero_i            combinational ALU zero flag
// ============================================================================
`default_nettype none

module alu_share_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [3:0]  req_ctrl0_i,
    input  logic [3:0]  req_ctrl1_i,
    input  logic [31:0] req_src1_0_i,
    input  logic [31:0] req_src2_0_i,
    input  logic [31:0] req_src1_1_i,
    input  logic [31:0] req_src2_1_i,
    output logic [1:0]  resp_valid_o,
    input  logic [1:0]  resp_ready_i,
    output logic [31:0] resp_result_o,
    output logic        resp_zero_o,
    output logic        resp_err_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic        prio;
    logic        grant;
    logic [3:0]  op_ctrl;
    logic [31:0] op_src1;
    logic [31:0] op_src2;

    logic        any_valid;
    logic        win;
    logic [3:0]  win_ctrl;
    logic [31:0] win_src1;
    logic [31:0] win_src2;

    // Arbitration: with both ports valid the pointer decides, otherwise the
    // single valid port wins. win is only meaningful when any_valid is set.
    always_comb begin
        any_valid = |req_valid_i;
        win       = (&req_valid_i) ? prio : req_valid_i[1];
        win_ctrl  = win ? req_ctrl1_i  : req_ctrl0_i;
        win_src1  = win ? req_src1_1_i : req_src1_0_i;
        win_src2  = win ? req_src2_1_i : req_src2_0_i;
    end

    // Handshake and response-valid decode. Both follow the state register
    // directly, so an asynchronous reset drops resp_valid_o at once.
    always_comb begin
        req_ready_o = 2'b00;
        if (state == IDLE && any_valid) begin
            req_ready_o = win ? 2'b10 : 2'b01;
        end
        resp_valid_o = 2'b00;
        if (state == RESP) begin
            resp_valid_o = grant ? 2'b10 : 2'b01;
        end
    end

    // The ALU sees the latched operation only during EXEC and is held at
    // zero otherwise to keep its inputs quiet.
    always_comb begin
        alu_ctrl_o = 4'd0;
        alu_src1_o = 32'd0;
        alu_src2_o = 32'd0;
        if (state == EXEC) begin
            alu_ctrl_o = op_ctrl;
            alu_src1_o = op_src1;
            alu_src2_o = op_src2;
        end
    end

    // Sequencer. Codes 8-15 have bit 3 set; those go straight to RESP with
    // an error response and never reach the ALU. The pointer always moves to
    // the port that lost (or did not request), which gives round-robin.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            prio          <= 1'b0;
            grant         <= 1'b0;
            op_ctrl       <= 4'd0;
            op_src1       <= 32'd0;
            op_src2       <= 32'd0;
            resp_result_o <= 32'd0;
            resp_zero_o   <= 1'b0;
            resp_err_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant   <= win;
                        prio    <= ~win;
                        op_ctrl <= win_ctrl;
                        op_src1 <= win_src1;
                        op_src2 <= win_src2;
                        if (win_ctrl[3]) begin
                            resp_result_o <= 32'd0;
                            resp_zero_o   <= 1'b0;
                            resp_err_o    <= 1'b1;
                            state         <= RESP;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    resp_result_o <= alu_result_i;
                    resp_zero_o   <= alu_zero_i;
                    resp_err_o    <= 1'b0;
                    state         <= RESP;
                end
                RESP: begin
                    if (resp_ready_i[grant]) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
